// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: requester-side command/acknowledge bundle for the RAM port-1 arbiter
// Ports (signals): req0/req1 command requests; we_in0/we_in1 write enables;
// addr_in0/addr_in1 target addresses; wdata0/wdata1 write data; ack0/ack1 completion
// pulses; rdata read data; busy arbiter not idle.
// master modport: requesters' view. slave modport: arbiter's view.
interface ram_port_arbiter_if #(
    parameter int ADDRESS_SIZE = 4,
    parameter int WORD_SIZE = 32
);
    logic req0, req1, we_in0, we_in1;
    logic [ADDRESS_SIZE-1:0] addr_in0, addr_in1;
    logic [WORD_SIZE-1:0] wdata0, wdata1;
    logic ack0, ack1, busy;
    logic [WORD_SIZE-1:0] rdata;
    modport master(
        output req0, req1, we_in0, we_in1, addr_in0, addr_in1, wdata0, wdata1,
        input ack0, ack1, busy, rdata
    );
    modport slave(
        input req0, req1, we_in0, we_in1, addr_in0, addr_in1, wdata0, wdata1,
        output ack0, ack1, busy, rdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin arbiter/sequencer for two requesters sharing RAM port 1
// Ports: clk system clock; rst synchronous active-high reset; bus requester bundle
// (slave side); ram_we/ram_addr/ram_data drive RAM we1/addr1/data1, ram_data is
// driven only during a write ACCESS cycle and is high-Z otherwise.
module ram_port_arbiter #(
    parameter int ADDRESS_SIZE = 4,
    parameter int WORD_SIZE = 32
) (
    input logic clk,
    input logic rst,
    ram_port_arbiter_if.slave bus,
    output logic ram_we,
    output logic [ADDRESS_SIZE-1:0] ram_addr,
    inout wire [WORD_SIZE-1:0] ram_data
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
    state_t state;
    logic prio, id, win;
    logic [WORD_SIZE-1:0] l_wdata;
    // prio names the requester that wins a tie
    assign win = bus.req1 && (!bus.req0 || prio);
    // ram_we is high only in a write ACCESS cycle, so it doubles as the output enable
    assign ram_data = ram_we ? l_wdata : 'z;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            prio <= 1'b0;
            id <= 1'b0;
            l_wdata <= '0;
            ram_we <= 1'b0;
            ram_addr <= '0;
            bus.ack0 <= 1'b0;
            bus.ack1 <= 1'b0;
            bus.rdata <= '0;
            bus.busy <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req0 || bus.req1) begin
                    state <= ACCESS;
                    bus.busy <= 1'b1;
                    id <= win;
                    prio <= !win;
                    ram_we <= win ? bus.we_in1 : bus.we_in0;
                    ram_addr <= win ? bus.addr_in1 : bus.addr_in0;
                    l_wdata <= win ? bus.wdata1 : bus.wdata0;
                end
                ACCESS: begin
                    // ram_we still holds the latched command type here
                    ram_we <= 1'b0;
                    state <= ram_we ? DONE : WAIT;
                    bus.ack0 <= ram_we && !id;
                    bus.ack1 <= ram_we && id;
                end
                WAIT: begin
                    bus.rdata <= ram_data;
                    bus.ack0 <= !id;
                    bus.ack1 <= id;
                    state <= DONE;
                end
                DONE: begin
                    bus.ack0 <= 1'b0;
                    bus.ack1 <= 1'b0;
                    bus.busy <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed plus randomized check of ram_port_arbiter against a transaction model
module tb_ram_port_arbiter;
    localparam int A = 4;
    localparam int W = 32;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    ram_port_arbiter_if #(.ADDRESS_SIZE(A), .WORD_SIZE(W)) bus();
    logic ram_we;
    logic [A-1:0] ram_addr;
    wire [W-1:0] data1;
    logic [W-1:0] mem[16];
    assign data1 = ram_we ? 'z : mem[ram_addr];
    always @(posedge clk) if (ram_we) mem[ram_addr] <= data1;
    ram_port_arbiter #(.ADDRESS_SIZE(A), .WORD_SIZE(W)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(data1)
    );
    logic req[2], we[2];
    logic [A-1:0] addr[2];
    logic [W-1:0] wd[2];
    assign bus.req0 = req[0];
    assign bus.req1 = req[1];
    assign bus.we_in0 = we[0];
    assign bus.we_in1 = we[1];
    assign bus.addr_in0 = addr[0];
    assign bus.addr_in1 = addr[1];
    assign bus.wdata0 = wd[0];
    assign bus.wdata1 = wd[1];
    int cyc = 0, idle_at = 0, grant_c = -10, ack_c = -1, total = 0, bad = 0, mode = 0;
    logic g_id = 1'b0, g_we = 1'b0, prio_m = 1'b0, rst_prev = 1'b0;
    logic [A-1:0] g_addr = '0;
    logic [W-1:0] g_wdata = '0, rd_val = '0, exp_rdata = '0;
    logic [W-1:0] mem_m[16];
    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask
    task automatic check();
        bit in_acc;
        in_acc = (cyc == grant_c + 1);
        if (cyc == ack_c && !g_we) exp_rdata = rd_val;
        chk("ack0", W'(bus.ack0), W'(cyc == ack_c && g_id == 1'b0));
        chk("ack1", W'(bus.ack1), W'(cyc == ack_c && g_id == 1'b1));
        chk("busy", W'(bus.busy), W'(cyc > grant_c && cyc < idle_at));
        chk("rdata", bus.rdata, exp_rdata);
        chk("ram_we", W'(ram_we), W'(g_we && in_acc));
        if (cyc > grant_c && cyc < ack_c) chk("ram_addr", W'(ram_addr), W'(g_addr));
        if (g_we && in_acc) chk("ram_data", data1, g_wdata);
        if (rst_prev) chk("rst_addr", W'(ram_addr), '0);
    endtask
    // transaction-level model: one command served at a time, fixed write/read latency
    task automatic model_arb();
        rst_prev = rst;
        if (rst) begin
            idle_at = cyc + 1;
            grant_c = -10;
            ack_c = -1;
            prio_m = 1'b0;
            exp_rdata = '0;
            g_we = 1'b0;
        end else if (cyc >= idle_at && (req[0] || req[1])) begin
            if (req[0] && req[1]) g_id = prio_m;
            else g_id = req[1];
            prio_m = !g_id;
            g_we = we[g_id];
            g_addr = addr[g_id];
            g_wdata = wd[g_id];
            grant_c = cyc;
            ack_c = cyc + (g_we ? 2 : 3);
            idle_at = ack_c + 1;
            if (g_we) mem_m[g_addr] = g_wdata;
            else rd_val = mem_m[g_addr];
        end
    endtask
    task automatic new_cmd(input int r);
        req[r] = 1'b1;
        we[r] = 1'($urandom_range(1));
        addr[r] = A'($urandom);
        wd[r] = $urandom;
    endtask
    task automatic drivers();
        for (int r = 0; r < 2; r++) begin
            if (mode != 0 && g_id == 1'(r) && cyc > grant_c && cyc <= ack_c && $urandom_range(1) == 1) begin
                wd[r] = $urandom;
                addr[r] = A'($urandom);
            end
            if ((g_id == 1'(r) && cyc == ack_c + 1) || (mode != 0 && !req[r])) begin
                if (mode == 2 || (mode == 1 && $urandom_range(1) == 1)) new_cmd(r);
                else req[r] = 1'b0;
            end
        end
    endtask
    task automatic run(input int n);
        repeat (n) begin
            drivers();
            model_arb();
            @(posedge clk);
            @(negedge clk);
            cyc++;
            check();
        end
    endtask
    task automatic set(input int r, input logic w, input logic [A-1:0] a, input logic [W-1:0] d);
        req[r] = 1'b1;
        we[r] = w;
        addr[r] = a;
        wd[r] = d;
    endtask
    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i] = '0;
            mem_m[i] = '0;
        end
        for (int r = 0; r < 2; r++) begin
            req[r] = 1'b0;
            we[r] = 1'b0;
            addr[r] = '0;
            wd[r] = '0;
        end
        @(negedge clk);
        run(2);
        rst = 1'b0;
        run(1);
        set(0, 1'b1, 4'd3, 32'haaaaaaaa);
        run(5);
        set(1, 1'b0, 4'd3, 32'h0);
        run(6);
        set(0, 1'b1, 4'd5, 32'h12345678);
        run(1);
        rst = 1'b1;
        req[0] = 1'b0;
        run(2);
        rst = 1'b0;
        run(2);
        set(0, 1'b1, 4'd1, 32'h55555555);
        set(1, 1'b0, 4'd1, 32'h0);
        run(10);
        set(1, 1'b0, 4'd3, 32'h0);
        run(6);
        mode = 2;
        run(24);
        mode = 1;
        run(3000);
        mode = 0;
        run(8);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Round-robin arbiter and sequencer for the shared read/write port (port 1) of the accelerator's RAM. Two requesters (the ODE solver core and the host loader) issue single-word read or write commands. The block grants one at a time, drives the RAM's `we1`/`addr1`/bidirectional `data1` pins, and returns read data with a one-cycle acknowledge pulse. The RAM's read-only port 2 is untouched by this block.

## Interface
Parameters:
- ADDRESS_SIZE, 4, RAM address width
- WORD_SIZE, 32, RAM word width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0 / req1  in  1  command request from requester 0 / 1; held high with stable command until ack
- we_in0 / we_in1  in  1  1 = write, 0 = read
- addr_in0 / addr_in1  in  ADDRESS_SIZE  target address
- wdata0 / wdata1  in  WORD_SIZE  write data
- ack0 / ack1  out  1  one-cycle completion pulse to the granted requester
- rdata  out  WORD_SIZE  read data, valid while ack0/ack1 high, held afterwards until next read completes
- busy  out  1  high in any state other than IDLE
- ram_we  out  1  to RAM `we1`
- ram_addr  out  ADDRESS_SIZE  to RAM `addr1`
- ram_data  inout  WORD_SIZE  to RAM `data1`; driven with latched write data only while ram_we=1, else high-Z

## Operation
- State machine states: IDLE, ACCESS, WAIT, DONE. All outputs are registered or decoded from state and latched command. No combinational path exists from req to RAM pins.
- IDLE: if any req is high, pick a winner:
  - If only one requester is high, it wins.
  - If both are high, the winner is the one named by priority bit `prio`.
  - Latch the winner's we/addr/wdata and ID. Set prio to the other requester. Go to ACCESS.
  - If no req is high, stay in IDLE.
- ACCESS: ram_addr = latched addr. ram_we = latched we. ram_data driven with latched wdata if write.
  - A write commits at the end of this cycle; go to DONE.
  - A read goes to WAIT.
- WAIT (reads only): ram_addr held, ram_we=0. Capture ram_data into rdata at the end of the cycle; go to DONE. This tolerates both combinational and registered RAM reads.
- DONE: assert ack of the latched ID for exactly one cycle, ram_we=0, then go to IDLE.
- Requester protocol:
  - Drop req, or present a new command, in the cycle after ack.
  - A req still high when IDLE is re-entered is treated as a new command.
  - Changing the command while req is high and before ack is illegal; the latched copy is used.
- Non-granted requester: its ack stays 0; its req remains pending and wins the next IDLE arbitration if the other requester is absent or prio points to it.
- Write data never appears on ram_data during reads, WAIT, DONE or IDLE, so the bus has no contention.

## Timing
- Reset values (applied at the clk edge with rst=1, from any state, aborting any transaction):
  - state IDLE
  - ram_we=0, ram_addr=0, ram_data=Z
  - ack0=ack1=0, rdata=0, busy=0, prio=0
- An aborted transaction produces no ack.
- Write latency: req high in IDLE cycle c, ACCESS in c+1 (RAM write at end of c+1), ack in c+2, IDLE in c+3. Sustained throughput is one write per 3 cycles.
- Read latency: IDLE c, ACCESS c+1, WAIT c+2 (capture), ack with valid rdata in c+3, IDLE in c+4.
- With both requesters continuously requesting, grants strictly alternate 0,1,0,1,… starting with 0 after reset.
- A req arriving while busy is not sampled until the next IDLE cycle.
- Address wrap-around is not applicable: every address 0..2^ADDRESS_SIZE-1 is accessed directly.

## Test plan
- Reset: hold rst 2 cycles mid-write (in ACCESS) -> next cycle ram_we=0, ram_data=Z, no ack, busy=0, rdata=0.
- Single write/read: req0 writes 32'haaaaaaaa to addr 3 -> ack0 2 cycles after IDLE sample and RAM1.MEM[3]=32'haaaaaaaa. req1 then reads addr 3 -> ack1 3 cycles after sample with rdata=32'haaaaaaaa.
- Simultaneous requests: after reset, req0 writes 32'h55555555 to addr 1 and req1 reads addr 1, both raised in the same cycle -> port 0 served first; req1 then gets rdata=32'h55555555. ack0 and ack1 are never high together.
- Fairness: hold req0 and req1 high for 4 transactions, each re-requesting after its ack -> ack order 0,1,0,1. No requester waits more than one transaction.
- Bus hygiene: during a read transaction and in IDLE, ram_data reads Z from the arbiter side. During a write ACCESS cycle, ram_data equals the latched wdata even if wdata0 changes after grant.
- Memory isolation: write addr 3 = 32'haaaaaaaa, then addr 1 = 32'h55555555 -> read-back of addr 3 still returns 32'haaaaaaaa.
